// File: rtl/hex_word_sender.sv
// Prints a word as ASCII hex digits, MSB nibble first, optionally followed
// by CR LF, one byte at a time through a ready/offer handshake to a UART.
module hex_word_sender #(
   parameter int WORD_NIBBLES = 8,
   parameter int SEND_CRLF    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*WORD_NIBBLES-1:0] word_in,
   input  logic                      word_valid,
   output logic                      word_ready,
   output logic [7:0]                data_to_send,
   output logic                      data_to_send_ready,
   input  logic                      ready_to_send,
   output logic                      busy
);

   localparam int TOTAL = WORD_NIBBLES + 2 * SEND_CRLF;
   localparam int IDX_W = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RDY,
      PRESENT
   } state_t;

   state_t                    state, state_n;
   logic [4*WORD_NIBBLES-1:0] word_q;
   logic [IDX_W-1:0]          idx;
   logic [3:0]                nib;
   logic [7:0]                cur_char;
   logic                      last;
   logic                      word_ld;
   logic                      idx_inc;
   logic                      char_ld;

   assign word_ready         = (state == IDLE) && !reset;
   assign busy               = (state != IDLE);
   assign data_to_send_ready = (state == PRESENT);
   assign last               = (idx == IDX_W'(TOTAL - 1));

   always_comb begin
      nib = '0;
      for (int i = 0; i < WORD_NIBBLES; i++) begin
         if (int'(idx) == WORD_NIBBLES - 1 - i)
            nib = word_q[4*i +: 4];
      end
   end

   // Digits first, then CR, then LF once the index runs past the nibbles.
   always_comb begin
      cur_char = 8'h0A;
      if (int'(idx) < WORD_NIBBLES) begin
         if (nib < 4'd10)
            cur_char = {4'h3, nib};
         else
            cur_char = 8'h37 + {4'h0, nib};
      end else if (int'(idx) == WORD_NIBBLES) begin
         cur_char = 8'h0D;
      end
   end

   always_comb begin
      state_n = state;
      word_ld = 1'b0;
      idx_inc = 1'b0;
      char_ld = 1'b0;
      unique case (state)
         IDLE: begin
            if (word_valid) begin
               word_ld = 1'b1;
               state_n = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (ready_to_send) begin
               char_ld = 1'b1;
               state_n = PRESENT;
            end
         end
         PRESENT: begin
            // The sender dropping ready means it has latched our byte.
            if (!ready_to_send) begin
               idx_inc = 1'b1;
               state_n = last ? IDLE : WAIT_RDY;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         word_q       <= '0;
         idx          <= '0;
         data_to_send <= 8'h00;
      end else begin
         state <= state_n;
         if (word_ld) begin
            word_q <= word_in;
            idx    <= '0;
         end else if (idx_inc) begin
            idx <= idx + 1'b1;
         end
         if (char_ld)
            data_to_send <= cur_char;
      end
   end

endmodule

// File: tb/tb_hex_word_sender.sv
// Bench for hex_word_sender: UART sender models latch offered bytes and
// compare them against a queue of expected characters.
module tb_hex_word_sender;

   localparam int UART_PERIOD = 4;
   localparam int BYTE_CYCLES = 10 * UART_PERIOD;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] word_in;
   logic        word_valid;
   logic        word_ready;
   logic [7:0]  data_to_send;
   logic        data_to_send_ready;
   logic        ready_to_send;
   logic        busy;
   logic        hold;

   logic [7:0]  w2_in;
   logic        w2_valid;
   logic        w2_ready;
   logic [7:0]  d2;
   logic        d2_rdy;
   logic        rts2;
   logic        busy2;

   int          s_cnt = 0;
   int          s2_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          acc_n = 0;
   int          acc_q = 0;
   logic [7:0]  q[$];
   logic [7:0]  q2[$];

   always #5 clk = ~clk;

   hex_word_sender dut (
      .clk                (clk),
      .reset              (reset),
      .word_in            (word_in),
      .word_valid         (word_valid),
      .word_ready         (word_ready),
      .data_to_send       (data_to_send),
      .data_to_send_ready (data_to_send_ready),
      .ready_to_send      (ready_to_send),
      .busy               (busy)
   );

   hex_word_sender #(.WORD_NIBBLES(2), .SEND_CRLF(0)) dut2 (
      .clk                (clk),
      .reset              (reset),
      .word_in            (w2_in),
      .word_valid         (w2_valid),
      .word_ready         (w2_ready),
      .data_to_send       (d2),
      .data_to_send_ready (d2_rdy),
      .ready_to_send      (rts2),
      .busy               (busy2)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
   endfunction

   task automatic push_word(input logic [31:0] w);
      for (int i = 7; i >= 0; i--) q.push_back(hex_char(w[4*i +: 4]));
      q.push_back(8'h0D);
      q.push_back(8'h0A);
   endtask

   assign ready_to_send = (s_cnt == 0) && !hold;
   assign rts2          = (s2_cnt == 0);

   // Sender models: latch an offered byte when idle, then shift for a while.
   always @(posedge clk) begin
      if (s_cnt != 0) begin
         s_cnt <= s_cnt - 1;
      end else if (ready_to_send && data_to_send_ready) begin
         s_cnt <= BYTE_CYCLES;
         check("q_nonempty", 32'(q.size() != 0), 1);
         if (q.size() != 0) check("byte", data_to_send, q.pop_front());
      end
   end

   always @(posedge clk) begin
      if (s2_cnt != 0) begin
         s2_cnt <= s2_cnt - 1;
      end else if (rts2 && d2_rdy) begin
         s2_cnt <= BYTE_CYCLES;
         check("q2_nonempty", 32'(q2.size() != 0), 1);
         if (q2.size() != 0) check("byte2", d2, q2.pop_front());
      end
   end

   always @(posedge clk) begin
      if (word_valid && word_ready) begin
         acc_n++;
         acc_q = q.size();
      end
   end

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (q.size() == 0 && q2.size() == 0 && !busy && !busy2 &&
             s_cnt == 0 && s2_cnt == 0)
            break;
      end
      check({tag, "_drain"}, q.size() + q2.size(), 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int  a0;
      bit  seen;
      bit  found;
      reset      = 1'b1;
      hold       = 1'b0;
      word_in    = '0;
      word_valid = 1'b0;
      w2_in      = '0;
      w2_valid   = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_dtsr", data_to_send_ready, 0);
      check("rst_data", data_to_send, 0);
      check("rst_busy", busy, 0);
      check("rst_wrdy", word_ready, 0);
      reset = 1'b0;
      #1 check("rel_wrdy", word_ready, 1);

      // Basic word; word_in changes after accept must not matter.
      @(negedge clk);
      push_word(32'h1234ABCD);
      word_in    = 32'h1234ABCD;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      word_in    = 32'hDEADBEEF;
      check("acc_busy", busy, 1);
      wait_done("w1");

      // Back-to-back words with word_valid held high.
      push_word(32'h00000000);
      push_word(32'hFFFFFFFF);
      a0         = acc_n;
      word_in    = 32'h00000000;
      word_valid = 1'b1;
      @(negedge clk);
      word_in = 32'hFFFFFFFF;
      for (int i = 0; i < 2000 && acc_n < a0 + 2; i++) @(negedge clk);
      word_valid = 1'b0;
      check("b2b_acc", acc_n - a0, 2);
      check("b2b_q_at_acc", acc_q, 10);
      wait_done("b2b");

      // Sender held not-ready at accept time.
      hold       = 1'b1;
      push_word(32'h0000000F);
      word_in    = 32'h0000000F;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      seen       = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_to_send_ready) seen = 1'b1;
      end
      check("hold_dtsr", seen, 0);
      check("hold_busy", busy, 1);
      hold = 1'b0;
      wait_done("hold");

      // Reset while char 3 is on offer: only chars 0..2 go out.
      q.push_back(8'h31);
      q.push_back(8'h32);
      q.push_back(8'h33);
      word_in    = 32'h1234ABCD;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      found      = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (data_to_send_ready && data_to_send == 8'h34) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_found", found, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_dtsr", data_to_send_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_wrdy", word_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("mid_rel_wrdy", word_ready, 1);
      repeat (300) @(negedge clk);
      check("mid_no_more", q.size(), 0);
      check("mid_idle", busy, 0);

      // Two-nibble, no CRLF instance with latency check.
      q2.push_back(8'h46);
      q2.push_back(8'h30);
      w2_in    = 8'hF0;
      w2_valid = 1'b1;
      @(negedge clk);
      w2_valid = 1'b0;
      check("lat_k", d2_rdy, 0);
      check("lat_k_busy", busy2, 1);
      @(negedge clk);
      check("lat_k1", d2_rdy, 1);
      check("lat_k1_data", d2, 8'h46);
      wait_done("n2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
